// File: rtl/pkt_demux.sv
// Framed symbol-stream demux: strips ordered sets and splits STP/SDP packets onto TLP/DLLP ports.
// Optional per-port good-packet counters are enabled with `define PKT_DEMUX_STATS_EN.
module pkt_demux #(
  parameter int         MAX_LEN = 16,
  parameter logic [7:0] COM     = 8'hBC,
  parameter logic [7:0] SKP     = 8'h1C,
  parameter logic [7:0] STP     = 8'hFB,
  parameter logic [7:0] SDP     = 8'h5C,
  parameter logic [7:0] ENDS    = 8'hFD,
  parameter logic [7:0] IDL     = 8'h7C
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       valid,
  input  logic [7:0] data,
  output logic       tlp_valid,
  output logic [7:0] tlp_data,
  output logic       tlp_sop,
  output logic       tlp_eop,
  output logic       dllp_valid,
  output logic [7:0] dllp_data,
  output logic       dllp_sop,
  output logic       dllp_eop,
`ifdef PKT_DEMUX_STATS_EN
  output logic [7:0] tlp_cnt,
  output logic [7:0] dllp_cnt,
`endif
  output logic       err
);

  localparam int            CW      = $clog2(MAX_LEN + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_LEN);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  typedef enum logic [1:0] {ST_IDLE, ST_TLP, ST_DLLP, ST_DROP} state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [7:0]    hold, hold_n;
  logic          beat, beat_sop, beat_eop, beat_dllp, err_n, is_sym;

  assign is_sym = (data == COM) || (data == SKP) || (data == STP) ||
                  (data == SDP) || (data == ENDS) || (data == IDL);

  // cnt counts bytes taken into the current packet; the hold register is occupied whenever cnt != 0
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    hold_n    = hold;
    beat      = 1'b0;
    beat_sop  = 1'b0;
    beat_eop  = 1'b0;
    beat_dllp = (state == ST_DLLP);
    err_n     = 1'b0;
    if (valid) begin
      case (state)
        ST_IDLE: begin
          if (data == STP)
            state_n = ST_TLP;
          else if (data == SDP)
            state_n = ST_DLLP;
          else if (!((data == COM) || (data == SKP) || (data == IDL)))
            err_n = 1'b1;
        end
        ST_TLP, ST_DLLP: begin
          beat_sop = (cnt == CNT_ONE);
          if (!is_sym) begin
            if (cnt == CNT_MAX) begin
              beat     = 1'b1;
              beat_eop = 1'b1;
              err_n    = 1'b1;
              cnt_n    = '0;
              state_n  = ST_DROP;
            end else begin
              beat   = (cnt != '0);
              hold_n = data;
              cnt_n  = cnt + CNT_ONE;
            end
          end else if (data == ENDS) begin
            beat     = (cnt != '0);
            beat_eop = 1'b1;
            err_n    = (cnt == '0);
            cnt_n    = '0;
            state_n  = ST_IDLE;
          end else if (!((data == COM) || (data == SKP))) begin
            // IDL/STP/SDP abort the packet; STP/SDP also open a new one
            beat     = (cnt != '0);
            beat_eop = 1'b1;
            err_n    = 1'b1;
            cnt_n    = '0;
            if (data == STP)
              state_n = ST_TLP;
            else if (data == SDP)
              state_n = ST_DLLP;
            else
              state_n = ST_IDLE;
          end
        end
        ST_DROP: begin
          if ((data == ENDS) || (data == IDL))
            state_n = ST_IDLE;
          else if (data == STP)
            state_n = ST_TLP;
          else if (data == SDP)
            state_n = ST_DLLP;
        end
        default: state_n = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      hold       <= '0;
      tlp_valid  <= 1'b0;
      tlp_data   <= '0;
      tlp_sop    <= 1'b0;
      tlp_eop    <= 1'b0;
      dllp_valid <= 1'b0;
      dllp_data  <= '0;
      dllp_sop   <= 1'b0;
      dllp_eop   <= 1'b0;
      err        <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      hold       <= hold_n;
      tlp_valid  <= beat & ~beat_dllp;
      tlp_data   <= (beat & ~beat_dllp) ? hold : 8'h00;
      tlp_sop    <= beat & ~beat_dllp & beat_sop;
      tlp_eop    <= beat & ~beat_dllp & beat_eop;
      dllp_valid <= beat & beat_dllp;
      dllp_data  <= (beat & beat_dllp) ? hold : 8'h00;
      dllp_sop   <= beat & beat_dllp & beat_sop;
      dllp_eop   <= beat & beat_dllp & beat_eop;
      err        <= err_n;
    end
  end

`ifdef PKT_DEMUX_STATS_EN
  // Count error-free end-of-packet beats per port, saturating
  always_ff @(posedge clk) begin
    if (reset) begin
      tlp_cnt  <= '0;
      dllp_cnt <= '0;
    end else if (beat && beat_eop && !err_n) begin
      if (!beat_dllp && tlp_cnt != 8'hFF)
        tlp_cnt <= tlp_cnt + 8'd1;
      if (beat_dllp && dllp_cnt != 8'hFF)
        dllp_cnt <= dllp_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pkt_demux.sv
// Self-checking bench for pkt_demux: directed vector table, MAX_LEN=4 overflow/reset sequence,
// and a randomized stream checked against a queue-based packet model on two DUT sizes.
module tb_pkt_demux;

  localparam logic [7:0] C_COM = 8'hBC, C_SKP = 8'h1C, C_STP = 8'hFB;
  localparam logic [7:0] C_SDP = 8'h5C, C_END = 8'hFD, C_IDL = 8'h7C;

  logic clk = 1'b0;
  logic reset, valid;
  logic [7:0] data;
  logic [1:0] tlp_valid, tlp_sop, tlp_eop, dllp_valid, dllp_sop, dllp_eop, err;
  logic [1:0][7:0] tlp_data, dllp_data;
`ifdef PKT_DEMUX_STATS_EN
  logic [1:0][7:0] tlp_cnt, dllp_cnt;
  int tcnt[2], dcnt[2];
`endif

  typedef struct packed {
    logic       tv;
    logic       dv;
    logic [7:0] d;
    logic       sop;
    logic       eop;
    logic       err;
  } exp_t;

  typedef struct {
    string      name;
    logic       v;
    logic [7:0] d;
    exp_t       e;
  } vec_t;

  vec_t       vecs[$];
  logic [7:0] syms[6];
  logic [7:0] pkt[2][$];
  int         mode[2];
  int         total = 0;
  int         bad = 0;

  always #5 clk = ~clk;

  pkt_demux dut (
    .clk(clk), .reset(reset), .valid(valid), .data(data),
    .tlp_valid(tlp_valid[0]), .tlp_data(tlp_data[0]), .tlp_sop(tlp_sop[0]), .tlp_eop(tlp_eop[0]),
    .dllp_valid(dllp_valid[0]), .dllp_data(dllp_data[0]), .dllp_sop(dllp_sop[0]), .dllp_eop(dllp_eop[0]),
`ifdef PKT_DEMUX_STATS_EN
    .tlp_cnt(tlp_cnt[0]), .dllp_cnt(dllp_cnt[0]),
`endif
    .err(err[0])
  );

  pkt_demux #(.MAX_LEN(4)) dut4 (
    .clk(clk), .reset(reset), .valid(valid), .data(data),
    .tlp_valid(tlp_valid[1]), .tlp_data(tlp_data[1]), .tlp_sop(tlp_sop[1]), .tlp_eop(tlp_eop[1]),
    .dllp_valid(dllp_valid[1]), .dllp_data(dllp_data[1]), .dllp_sop(dllp_sop[1]), .dllp_eop(dllp_eop[1]),
`ifdef PKT_DEMUX_STATS_EN
    .tlp_cnt(tlp_cnt[1]), .dllp_cnt(dllp_cnt[1]),
`endif
    .err(err[1])
  );

  function automatic exp_t mkE(logic tv, logic dv, logic [7:0] d, logic sop, logic eop, logic e);
    exp_t r;
    r.tv = tv; r.dv = dv; r.d = d; r.sop = sop; r.eop = eop; r.err = e;
    return r;
  endfunction

  function automatic logic isSym(logic [7:0] d);
    return (d == C_COM) || (d == C_SKP) || (d == C_STP) || (d == C_SDP) || (d == C_END) || (d == C_IDL);
  endfunction

  function automatic void addVec(string name, logic v, logic [7:0] d, exp_t e);
    vec_t r;
    r.name = name; r.v = v; r.d = d; r.e = e;
    vecs.push_back(r);
  endfunction

  task automatic applyStimulus(input logic v, input logic [7:0] d);
    @(negedge clk);
    reset = 1'b0;
    valid = v;
    data  = d;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input int inst, input exp_t e);
    logic [7:0] ad;
    logic ok;
    total++;
    ad = tlp_valid[inst] ? tlp_data[inst] : dllp_data[inst];
    ok = (tlp_valid[inst] == e.tv) && (dllp_valid[inst] == e.dv) && (err[inst] == e.err) &&
         (tlp_sop[inst] == (e.tv & e.sop)) && (tlp_eop[inst] == (e.tv & e.eop)) &&
         (dllp_sop[inst] == (e.dv & e.sop)) && (dllp_eop[inst] == (e.dv & e.eop)) &&
         (!(e.tv || e.dv) || ad == e.d);
    if (!ok) begin
      bad++;
      $display("[TB] FAIL %s inst%0d: got tv=%b dv=%b d=%h tsop=%b teop=%b dsop=%b deop=%b err=%b; want tv=%b dv=%b d=%h sop=%b eop=%b err=%b",
               name, inst, tlp_valid[inst], dllp_valid[inst], ad, tlp_sop[inst], tlp_eop[inst],
               dllp_sop[inst], dllp_eop[inst], err[inst], e.tv, e.dv, e.d, e.sop, e.eop, e.err);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < 2; i++) begin
      pkt[i].delete();
      mode[i] = 0;
`ifdef PKT_DEMUX_STATS_EN
      tcnt[i] = 0;
      dcnt[i] = 0;
`endif
    end
  endtask

  // Packet-level reference: mode 0=idle 1=tlp 2=dllp 3=drop; pkt holds every byte of the open packet
  task automatic modelStep(input int inst, input int maxLen, input logic v, input logic [7:0] d, output exp_t e);
    int n;
    e = '0;
    if (!v) return;
    n = pkt[inst].size();
    case (mode[inst])
      0: begin
        if (d == C_STP) mode[inst] = 1;
        else if (d == C_SDP) mode[inst] = 2;
        else if (!(d == C_COM || d == C_SKP || d == C_IDL)) e.err = 1'b1;
      end
      1, 2: begin
        if (n > 0) begin
          e.d   = pkt[inst][n-1];
          e.sop = (n == 1);
        end
        if (!isSym(d)) begin
          if (n == maxLen) begin
            e.tv = (mode[inst] == 1); e.dv = (mode[inst] == 2);
            e.eop = 1'b1; e.err = 1'b1;
            pkt[inst].delete();
            mode[inst] = 3;
          end else begin
            e.tv = (n > 0) && (mode[inst] == 1);
            e.dv = (n > 0) && (mode[inst] == 2);
            pkt[inst].push_back(d);
          end
        end else if (d == C_END) begin
          e.tv = (n > 0) && (mode[inst] == 1);
          e.dv = (n > 0) && (mode[inst] == 2);
          e.eop = (n > 0);
          e.err = (n == 0);
          pkt[inst].delete();
          mode[inst] = 0;
        end else if (!(d == C_COM || d == C_SKP)) begin
          e.tv = (n > 0) && (mode[inst] == 1);
          e.dv = (n > 0) && (mode[inst] == 2);
          e.eop = (n > 0);
          e.err = 1'b1;
          pkt[inst].delete();
          mode[inst] = (d == C_STP) ? 1 : (d == C_SDP) ? 2 : 0;
        end
        if (!(e.tv || e.dv)) begin
          e.sop = 1'b0;
          e.d = 8'h00;
        end
      end
      default: begin
        if (d == C_END || d == C_IDL) mode[inst] = 0;
        else if (d == C_STP) mode[inst] = 1;
        else if (d == C_SDP) mode[inst] = 2;
      end
    endcase
`ifdef PKT_DEMUX_STATS_EN
    if (e.eop && !e.err && e.tv && tcnt[inst] < 255) tcnt[inst]++;
    if (e.eop && !e.err && e.dv && dcnt[inst] < 255) dcnt[inst]++;
`endif
  endtask

  task automatic checkResetState(input string name);
    for (int i = 0; i < 2; i++) begin
      checkOutput(name, i, '0);
      total++;
      if (tlp_data[i] !== 8'h00 || dllp_data[i] !== 8'h00) begin
        bad++;
        $display("[TB] FAIL %s_data inst%0d: got tlp_data=%h dllp_data=%h, want 00 00", name, i, tlp_data[i], dllp_data[i]);
      end
    end
  endtask

  task automatic doReset(input logic v, input logic [7:0] d);
    @(negedge clk);
    reset = 1'b1;
    valid = v;
    data  = d;
    @(posedge clk);
    #1;
    modelReset();
    checkResetState("reset");
  endtask

  initial begin
    exp_t n0, e;
    exp_t ex[2];
    logic v;
    logic [7:0] d;
    int thresh;
    n0 = '0;
    syms = '{C_COM, C_SKP, C_STP, C_SDP, C_END, C_IDL};
    reset = 1'b1;
    valid = 1'b0;
    data  = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    checkResetState("initial_reset");

    // directed vectors, checked on the MAX_LEN=16 instance
    for (int i = 0; i < 4; i++) addVec("t1_com", 1, C_COM, n0);
    addVec("t1_stp", 1, C_STP, n0);
    addVec("t1_b01", 1, 8'h01, n0);
    addVec("t1_b02", 1, 8'h02, mkE(1, 0, 8'h01, 1, 0, 0));
    addVec("t1_end", 1, C_END, mkE(1, 0, 8'h02, 0, 1, 0));
    addVec("t1_gap", 0, 8'h00, n0);
    for (int i = 0; i < 12; i++) addVec("t2_skp", 1, C_SKP, n0);
    for (int i = 0; i < 8; i++) addVec("t2_idl", 1, C_IDL, n0);
    addVec("t2_idle_byte", 1, 8'h55, mkE(0, 0, 8'h00, 0, 0, 1));
    addVec("t3_stp", 1, C_STP, n0);
    addVec("t3_b03", 1, 8'h03, n0);
    for (int b = 4; b <= 12; b++) addVec("t3_beat", 1, 8'(b), mkE(1, 0, 8'(b - 1), (b == 4), 0, 0));
    addVec("t3_end", 1, C_END, mkE(1, 0, 8'h0C, 0, 1, 0));
    addVec("t4_sdp", 1, C_SDP, n0);
    addVec("t4_b0d", 1, 8'h0D, n0);
    addVec("t4_b0e", 1, 8'h0E, mkE(0, 1, 8'h0D, 1, 0, 0));
    addVec("t4_end", 1, C_END, mkE(0, 1, 8'h0E, 0, 1, 0));
    addVec("t5_stp", 1, C_STP, n0);
    addVec("t5_b01", 1, 8'h01, n0);
    addVec("t5_idl_abort", 1, C_IDL, mkE(1, 0, 8'h01, 1, 1, 1));
    addVec("t5_stp2", 1, C_STP, n0);
    addVec("t5_empty_end", 1, C_END, mkE(0, 0, 8'h00, 0, 0, 1));
    addVec("t5_idle_end", 1, C_END, mkE(0, 0, 8'h00, 0, 0, 1));
    addVec("ab_stp", 1, C_STP, n0);
    addVec("ab_b01", 1, 8'h01, n0);
    addVec("ab_sdp_abort", 1, C_SDP, mkE(1, 0, 8'h01, 1, 1, 1));
    addVec("ab_b02", 1, 8'h02, n0);
    addVec("ab_end", 1, C_END, mkE(0, 1, 8'h02, 1, 1, 0));
    addVec("gap_stp", 1, C_STP, n0);
    addVec("gap_b0a", 1, 8'h0A, n0);
    addVec("gap_hole", 0, 8'h33, n0);
    addVec("gap_b0b", 1, 8'h0B, mkE(1, 0, 8'h0A, 1, 0, 0));
    addVec("gap_com", 1, C_COM, n0);
    addVec("gap_end", 1, C_END, mkE(1, 0, 8'h0B, 0, 1, 0));

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].v, vecs[i].d);
      checkOutput(vecs[i].name, 0, vecs[i].e);
    end

    // MAX_LEN=4 overflow, silent END out of DROP, then reset mid-packet
    doReset(1'b0, 8'h00);
    applyStimulus(1, C_STP);  checkOutput("t6_stp", 1, n0);
    applyStimulus(1, 8'h01);  checkOutput("t6_b01", 1, n0);
    applyStimulus(1, 8'h02);  checkOutput("t6_b02", 1, mkE(1, 0, 8'h01, 1, 0, 0));
    applyStimulus(1, 8'h03);  checkOutput("t6_b03", 1, mkE(1, 0, 8'h02, 0, 0, 0));
    applyStimulus(1, 8'h04);  checkOutput("t6_b04", 1, mkE(1, 0, 8'h03, 0, 0, 0));
    applyStimulus(1, 8'h05);  checkOutput("t6_overflow", 1, mkE(1, 0, 8'h04, 0, 1, 1));
    applyStimulus(1, C_END);  checkOutput("t6_drop_end", 1, n0);
    applyStimulus(1, C_STP);  checkOutput("t6_stp2", 1, n0);
    applyStimulus(1, 8'h21);  checkOutput("t6_b21", 1, n0);
    applyStimulus(1, 8'h22);  checkOutput("t6_b22", 1, mkE(1, 0, 8'h21, 1, 0, 0));
    doReset(1'b1, 8'h23);
    applyStimulus(1, C_END);  checkOutput("t6_after_reset", 1, mkE(0, 0, 8'h00, 0, 0, 1));

    // randomized stream against the packet model, alternating short and long packet phases
    doReset(1'b0, 8'h00);
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if ($urandom_range(0, 299) == 0) begin
        doReset($urandom_range(0, 1) == 1, 8'($urandom_range(0, 255)));
      end else begin
        thresh = ((cyc / 500) % 2 == 1) ? 6 : 35;
        v = ($urandom_range(0, 99) < 85);
        if ($urandom_range(0, 99) < thresh) begin
          d = syms[$urandom_range(0, 5)];
        end else begin
          d = 8'($urandom_range(0, 255));
          while (isSym(d)) d = 8'($urandom_range(0, 255));
        end
        applyStimulus(v, d);
        modelStep(0, 16, v, d, e);
        ex[0] = e;
        modelStep(1, 4, v, d, e);
        ex[1] = e;
        for (int i = 0; i < 2; i++) begin
          checkOutput("rand", i, ex[i]);
`ifdef PKT_DEMUX_STATS_EN
          total++;
          if (tlp_cnt[i] != 8'(tcnt[i]) || dllp_cnt[i] != 8'(dcnt[i])) begin
            bad++;
            $display("[TB] FAIL stats inst%0d: got tlp_cnt=%0d dllp_cnt=%0d, want %0d %0d",
                     i, tlp_cnt[i], dllp_cnt[i], tcnt[i], dcnt[i]);
          end
`endif
        end
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
